mux10to1_sel: RTL and testbench

Registered 10-to-1 single-bit multiplexer with select-range checking. On every rising clock edge it samples a 10-bit data bus and a 4-bit select, and registers the selected bit. Out-of-range selects produce a safe zero output and a flag. It serves as a generic bit-select stage wherever one line of a 10-line bus must be routed to a single consumer.

---
 rtl/mux10to1_sel.sv | 55 +++++
 tb/tb_mux10to1_sel.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux10to1_sel.sv
// Registered N_IN-to-1 bit multiplexer with one-hot select decode and an
// out-of-range flag; one cycle of latency, no internal history.
module mux10to1_sel #(
    parameter int N_IN  = 10,
    parameter int SEL_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_IN-1:0]   IN,
    input  logic [SEL_W-1:0]  SL,
    output logic              OUT,
    output logic              ERR,
    output logic [N_IN-1:0]   SEL_OH
);

    if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
        $fatal(1, "mux10to1_sel: N_IN must be in 2..16");
    end
    if (N_IN > (2 ** SEL_W)) begin : g_bad_sel_w
        $fatal(1, "mux10to1_sel: SEL_W too narrow to address N_IN inputs");
    end

    logic              out_d,    out_q;
    logic              err_d,    err_q;
    logic [N_IN-1:0]   sel_oh_d, sel_oh_q;

    // An out-of-range select matches no decode line, so the one-hot vector,
    // and therefore the output, is zero without any wrap of the index.
    always_comb begin
        sel_oh_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            sel_oh_d[i] = (SL == SEL_W'(i));
        end
        err_d = ~|sel_oh_d;
        // AND-masking keeps X/Z on unselected lines out of the result.
        out_d = |(IN & sel_oh_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q    <= 1'b0;
            err_q    <= 1'b0;
            sel_oh_q <= '0;
        end else begin
            out_q    <= out_d;
            err_q    <= err_d;
            sel_oh_q <= sel_oh_d;
        end
    end

    assign OUT    = out_q;
    assign ERR    = err_q;
    assign SEL_OH = sel_oh_q;

endmodule

// File: tb/tb_mux10to1_sel.sv
// Directed testbench for mux10to1_sel at default parameters.
module tb_mux10to1_sel;

    logic       CLK;
    logic       RST;
    logic [9:0] IN;
    logic [3:0] SL;
    logic       OUT;
    logic       ERR;
    logic [9:0] SEL_OH;

    int checks = 0;
    int errors = 0;

    mux10to1_sel #(.N_IN(10), .SEL_W(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .IN     (IN),
        .SL     (SL),
        .OUT    (OUT),
        .ERR    (ERR),
        .SEL_OH (SEL_OH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        IN  = 10'h3FF;
        SL  = 4'd3;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (OUT !== 1'b0 || ERR !== 1'b0 || SEL_OH !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: OUT=%b ERR=%b SEL_OH=%b, required 0 0 0000000000",
                         c, OUT, ERR, SEL_OH);
            end
        end
        RST = 1'b0;
        step();
        checks++;
        if (OUT !== 1'b1 || ERR !== 1'b0 || SEL_OH !== 10'b0000001000) begin
            errors++;
            $display("FAIL reset_release: OUT=%b ERR=%b SEL_OH=%b, required 1 0 0000001000",
                     OUT, ERR, SEL_OH);
        end
    endtask

    task automatic test_walk(input int v_lo, input int v_hi, input int v_rst);
        logic [7:0] v8;
        logic [3:0] s;
        logic       exp_out;
        logic       exp_err;
        logic [9:0] exp_oh;
        for (int v = v_lo; v <= v_hi; v++) begin
            v8  = 8'(v);
            s   = v8[6:3];
            IN  = 10'(1) << (v % 10);
            SL  = s;
            RST = (v == v_rst);
            step();
            if (v == v_rst) begin
                exp_out = 1'b0;
                exp_err = 1'b0;
                exp_oh  = 10'h000;
            end else begin
                exp_out = (s < 4'd10) && ((v % 10) == int'(s));
                exp_err = (s >= 4'd10);
                exp_oh  = (s < 4'd10) ? (10'(1) << s) : 10'h000;
            end
            checks++;
            if (OUT !== exp_out || ERR !== exp_err || SEL_OH !== exp_oh) begin
                errors++;
                $display("FAIL walk V=%0d SL=%0d: OUT=%b ERR=%b SEL_OH=%b, required %b %b %b",
                         v, s, OUT, ERR, SEL_OH, exp_out, exp_err, exp_oh);
            end
            checks++;
            if (OUT !== |(IN & SEL_OH)) begin
                errors++;
                $display("FAIL walk_invariant V=%0d: OUT=%b, required %b", v, OUT, |(IN & SEL_OH));
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_inverse();
        logic [9:0] pat;
        logic [9:0] one;
        for (int k = 0; k < 10; k++) begin
            one = 10'(1) << k;
            pat = 10'h3FF & ~one;
            IN  = pat;
            SL  = 4'(k);
            step();
            checks++;
            if (OUT !== 1'b0 || SEL_OH !== one || ERR !== 1'b0) begin
                errors++;
                $display("FAIL inverse_cleared k=%0d: OUT=%b SEL_OH=%b ERR=%b, required 0 %b 0",
                         k, OUT, SEL_OH, ERR, one);
            end
            SL = 4'((k + 1) % 10);
            step();
            checks++;
            if (OUT !== 1'b1) begin
                errors++;
                $display("FAIL inverse_neighbor k=%0d: OUT=%b, required 1", k, OUT);
            end
        end
    endtask

    task automatic test_out_of_range();
        IN = 10'h3FF;
        for (int s = 10; s <= 15; s++) begin
            SL = 4'(s);
            step();
            checks++;
            if (OUT !== 1'b0 || ERR !== 1'b1 || SEL_OH !== 10'h000) begin
                errors++;
                $display("FAIL out_of_range SL=%0d: OUT=%b ERR=%b SEL_OH=%b, required 0 1 0000000000",
                         s, OUT, ERR, SEL_OH);
            end
        end
        SL = 4'd9;
        step();
        checks++;
        if (OUT !== 1'b1 || ERR !== 1'b0 || SEL_OH !== 10'b1000000000) begin
            errors++;
            $display("FAIL range_recover: OUT=%b ERR=%b SEL_OH=%b, required 1 0 1000000000",
                     OUT, ERR, SEL_OH);
        end
    endtask

    task automatic test_latency();
        logic exp_out;
        IN = 10'b0000010000;
        for (int c = 0; c < 8; c++) begin
            SL = (c % 2 == 0) ? 4'd4 : 4'd5;
            exp_out = (c % 2 == 0);
            // Before the edge the output must still show the previous select.
            #3;
            checks++;
            if (c > 0 && OUT !== ~exp_out) begin
                errors++;
                $display("FAIL latency_pre c=%0d: OUT=%b, required %b", c, OUT, ~exp_out);
            end
            step();
            checks++;
            if (OUT !== exp_out) begin
                errors++;
                $display("FAIL latency_post c=%0d: OUT=%b, required %b", c, OUT, exp_out);
            end
        end
    endtask

    task automatic test_x_unselected();
        IN = 10'b0000000100;
        IN[7] = 1'bx;
        IN[0] = 1'bz;
        SL = 4'd2;
        step();
        checks++;
        if (OUT !== 1'b1) begin
            errors++;
            $display("FAIL x_unselected_one: OUT=%b, required 1", OUT);
        end
        IN[2] = 1'b0;
        step();
        checks++;
        if (OUT !== 1'b0) begin
            errors++;
            $display("FAIL x_unselected_zero: OUT=%b, required 0", OUT);
        end
    endtask

    initial begin
        RST = 1'b1;
        IN  = '0;
        SL  = '0;
        test_reset();
        test_walk(0, 254, -1);
        test_inverse();
        test_out_of_range();
        test_latency();
        test_x_unselected();
        test_walk(40, 70, 55);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
